// File: rtl/regfile_n_pkg.sv
// regfile_n_pkg -- constants and types shared by the register file and its users.
//   ADDR_W    : width of a register index
//   DEPTH     : number of registers (2**ADDR_W)
//   reg_idx_t : register index type used on every address port
package regfile_n_pkg;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  typedef logic [ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_n.sv
// regfile_n -- 16 x WIDTH register file, one write port, two combinational read ports.
//
// Ports:
//   clk        : clock, all writes on its rising edge
//   rst_n      : asynchronous active-low reset, clears every register at once
//   we         : write enable, active high
//   rd_addr1   : read port 1 register index
//   rd_addr2   : read port 2 register index
//   wr_addr    : write port register index
//   wr_data    : write data (WIDTH bits)
//   reg1_data  : contents of register rd_addr1 (combinational)
//   reg2_data  : contents of register rd_addr2 (combinational)
//
// Register 0 is an ordinary register. There is no write-to-read bypass: a read
// of the register being written shows the old value until the clock edge.
module regfile_n
  import regfile_n_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  reg_idx_t         rd_addr1,
  input  reg_idx_t         rd_addr2,
  input  reg_idx_t         wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] reg1_data,
  output logic [WIDTH-1:0] reg2_data
);

  logic [WIDTH-1:0] regs_q [DEPTH];

  // Asynchronous clear means the read ports show 0 as soon as rst_n falls,
  // and a held-low rst_n blocks any write regardless of we.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  assign reg1_data = regs_q[rd_addr1];
  assign reg2_data = regs_q[rd_addr2];

endmodule

// File: tb/tb_regfile_n.sv
// tb_regfile_n -- randomized scoreboard bench for regfile_n (WIDTH=32 and WIDTH=128 instances).
module tb_regfile_n;
  import regfile_n_pkg::*;

  localparam int EW = 32 + 32 + 128 + 128;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          we = 1'b0;
  reg_idx_t      rd_addr1 = '0;
  reg_idx_t      rd_addr2 = '0;
  reg_idx_t      wr_addr = '0;
  logic [31:0]   wd32 = '0;
  logic [127:0]  wd128 = '0;
  logic [31:0]   r1_32, r2_32;
  logic [127:0]  r1_128, r2_128;

  regfile_n #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .we(we),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .wr_addr(wr_addr),
    .wr_data(wd32), .reg1_data(r1_32), .reg2_data(r2_32)
  );

  regfile_n #(.WIDTH(128)) dut128 (
    .clk(clk), .rst_n(rst_n), .we(we),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .wr_addr(wr_addr),
    .wr_data(wd128), .reg1_data(r1_128), .reg2_data(r2_128)
  );

  // ---------------- reference model ----------------
  logic [31:0]  m32  [16];
  logic [127:0] m128 [16];

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m32[i]  = '0;
      m128[i] = '0;
    end
  endtask

  // Called right after a rising edge: a write lands only if enabled and out of reset.
  task automatic edge_model();
    if (we && rst_n) begin
      m32[int'(wr_addr)]  = wd32;
      m128[int'(wr_addr)] = wd128;
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  event          chk_ev;
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic cmp(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: each check request is resolved 1 time unit later from the queue.
  initial begin
    logic [EW-1:0] e;
    string nm;
    forever begin
      @(chk_ev);
      #1;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL monitor: got empty queue expected an entry at %0t", $time);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        cmp({nm, ".w32.p1"},  {96'd0, r1_32},  {96'd0, e[319:288]});
        cmp({nm, ".w32.p2"},  {96'd0, r2_32},  {96'd0, e[287:256]});
        cmp({nm, ".w128.p1"}, r1_128, e[255:128]);
        cmp({nm, ".w128.p2"}, r2_128, e[127:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input int a1, input int a2, input string nm);
    rd_addr1 = reg_idx_t'(a1);
    rd_addr2 = reg_idx_t'(a2);
    exp_q.push_back({m32[a1], m32[a2], m128[a1], m128[a2]});
    name_q.push_back(nm);
    ->chk_ev;
    #2;
  endtask

  task automatic do_write(input int a, input logic [31:0] d32, input logic [127:0] d128);
    we      = 1'b1;
    wr_addr = reg_idx_t'(a);
    wd32    = d32;
    wd128   = d128;
    @(posedge clk);
    edge_model();
    #1;
    we = 1'b0;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    // Writes attempted while in reset must be ignored.
    rst_n = 1'b0;
    we    = 1'b1;
    for (int c = 0; c < 3; c++) begin
      wr_addr = reg_idx_t'($urandom_range(0, 15));
      wd32    = $urandom;
      wd128   = rand128();
      @(posedge clk);
      edge_model();
      #1;
    end
    check(0, 15, "in_reset");
    check($urandom_range(0, 15), $urandom_range(0, 15), "in_reset_rand");
    we    = 1'b0;
    rst_n = 1'b1;
    check(3, 9, "after_reset");

    // Basic writes on each port.
    do_write(3, 32'd78, 128'd45);
    check(3, 3, "wr3");
    do_write(4, 32'd788, rand128());
    check(3, 4, "wr4_keep3");

    // we=0 must not disturb storage.
    we = 1'b0; wr_addr = 4'd3; wd32 = 32'd238; wd128 = 128'd238;
    repeat (4) begin
      @(posedge clk);
      edge_model();
    end
    #1;
    check(3, 4, "we0_hold");

    // Same-cycle read of the register being written: old before the edge, new after.
    we = 1'b1; wr_addr = 4'd5; wd32 = 32'hA5; wd128 = 128'hA5;
    check(5, 5, "nobypass_pre");
    @(posedge clk);
    edge_model();
    #1;
    we = 1'b0;
    check(5, 5, "nobypass_post");

    // Distinct value per register, then sweep both ports.
    for (int i = 0; i < 16; i++) begin
      logic [31:0] d;
      logic [127:0] dw;
      d = $urandom;
      d[3:0] = i[3:0];
      dw = rand128();
      dw[3:0] = i[3:0];
      do_write(i, d, dw);
    end
    for (int i = 0; i < 16; i++) check(i, 15 - i, "sweep");

    // All-ones pattern over the full width.
    for (int i = 0; i < 16; i++) do_write(i, '1, '1);
    for (int i = 0; i < 16; i++) check(i, (i + 7) % 16, "ones");

    // Random traffic.
    for (int c = 0; c < 300; c++) begin
      we      = 1'($urandom_range(0, 1));
      wr_addr = reg_idx_t'($urandom_range(0, 15));
      wd32    = $urandom;
      wd128   = rand128();
      @(posedge clk);
      edge_model();
      #1;
      check($urandom_range(0, 15), $urandom_range(0, 15), "rand");
    end
    we = 1'b0;

    // Mid-operation reset: outputs clear before the next clock edge.
    check(1, 2, "pre_midreset");
    rst_n = 1'b0;
    model_reset();
    check($urandom_range(0, 15), $urandom_range(0, 15), "midreset_immediate");
    we = 1'b1; wr_addr = 4'd7; wd32 = 32'hDEAD_BEEF; wd128 = '1;
    @(posedge clk);
    edge_model();
    #1;
    check(7, 7, "midreset_write_ignored");
    we    = 1'b0;
    rst_n = 1'b1;
    do_write(7, 32'h1234_5678, 128'hCAFE);
    check(7, 0, "post_midreset_write");

    #5;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
